// File: rtl/hamming_dist_unit.sv
// Serial Hamming-distance counter for an XOR difference vector: one bit per clock,
// start/busy/done handshake, threshold match flag and a saturating running total.
module hamming_dist_unit #(
    parameter int unsigned N      = 16,
    parameter int unsigned CW     = 5,
    parameter int unsigned AW     = 8,
    parameter int unsigned THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  x,
    input  logic          clear_acc,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          match,
    output logic [AW-1:0] acc,
    output logic          acc_sat
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [N-1:0]    sreg, sreg_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_add;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   count_n;
    logic            match_n;
    logic [AW-1:0]   acc_n, acc_base;
    logic            acc_sat_n;
    logic [AW:0]     acc_sum;
    logic            busy_n, done_n;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        cnt_n     = cnt;
        idx_n     = idx;
        count_n   = count;
        match_n   = match;
        acc_n     = acc;
        acc_sat_n = acc_sat;
        cnt_add   = cnt + CW'(sreg[0]);
        acc_base  = clear_acc ? '0 : acc;
        acc_sum   = (AW+1)'(acc_base) + (AW+1)'(count);

        if (clear_acc) begin
            acc_n     = '0;
            acc_sat_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    sreg_n  = x;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sreg_n = sreg >> 1;
                cnt_n  = cnt_add;
                idx_n  = idx + IW'(1);
                // Final bit is folded in on this edge, so publish the completed count now
                if (idx == IW'(N - 1)) begin
                    state_n = DONE;
                    count_n = cnt_add;
                    match_n = (cnt_add <= CW'(THRESH));
                end
            end
            DONE: begin
                // acc_base already reflects clear_acc, giving clear-then-add
                if (acc_sum[AW]) begin
                    acc_n     = '1;
                    acc_sat_n = 1'b1;
                end else begin
                    acc_n = acc_sum[AW-1:0];
                end
                if (start) begin
                    sreg_n  = x;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == SHIFT);
        done_n = (state_n == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            match   <= 1'b0;
            acc     <= '0;
            acc_sat <= 1'b0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            busy    <= busy_n;
            done    <= done_n;
            count   <= count_n;
            match   <= match_n;
            acc     <= acc_n;
            acc_sat <= acc_sat_n;
        end
    end

endmodule

// File: tb/tb_hamming_dist_unit.sv
// Scoreboard bench for hamming_dist_unit: expectations queued at start, checked on done.
module tb_hamming_dist_unit;

    localparam int unsigned N      = 16;
    localparam int unsigned CW     = 5;
    localparam int unsigned AW     = 8;
    localparam int unsigned THRESH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  x;
    logic          clear_acc;
    logic          busy, done, match, acc_sat;
    logic [CW-1:0] count;
    logic [AW-1:0] acc;

    typedef struct packed {
        logic [CW-1:0] c;
        logic          m;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_acc = 0;
    bit   m_sat = 1'b0;
    bit   pend  = 1'b0;
    bit   b2b   = 1'b0;
    bit   have_last = 1'b0;
    int   cyc = 0;
    int   last_done = 0;

    hamming_dist_unit #(.N(N), .CW(CW), .AW(AW), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .clear_acc(clear_acc),
        .busy(busy), .done(done), .count(count), .match(match),
        .acc(acc), .acc_sat(acc_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [N-1:0] w);
        exp_t e;
        e.c = CW'($countones(w));
        e.m = ($countones(w) <= THRESH);
        return e;
    endfunction

    // Monitor: pops expectations on done, checks acc one cycle later
    always @(negedge clk) begin
        exp_t e;
        int   base, sum;
        cyc++;
        if (rst) begin
            q.delete();
            pend  = 1'b0;
            m_acc = 0;
            m_sat = 1'b0;
            have_last = 1'b0;
        end else begin
            if (!b2b) have_last = 1'b0;
            if (pend) begin
                chk("acc", 32'(acc), 32'(m_acc));
                chk("acc_sat", 32'(acc_sat), 32'(m_sat));
                pend = 1'b0;
            end
            if (done) begin
                if (b2b && have_last) chk("done_gap", 32'(cyc - last_done), 32'(N + 1));
                last_done = cyc;
                have_last = 1'b1;
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("count", 32'(count), 32'(e.c));
                    chk("match", 32'(match), 32'(e.m));
                    base = clear_acc ? 0 : m_acc;
                    sum  = base + int'(e.c);
                    if (clear_acc) m_sat = 1'b0;
                    if (sum > (1 << AW) - 1) begin
                        m_acc = (1 << AW) - 1;
                        m_sat = 1'b1;
                    end else begin
                        m_acc = sum;
                    end
                    pend = 1'b1;
                end
            end else if (clear_acc) begin
                m_acc = 0;
                m_sat = 1'b0;
            end
        end
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge ending DONE
    task automatic run_word(input logic [N-1:0] w, input bit clr, input bit noise);
        int busy_n;
        start = 1'b1;
        x     = w;
        q.push_back(mk_exp(w));
        @(posedge clk); #1;
        start  = 1'b0;
        x      = N'($urandom);
        busy_n = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (busy) busy_n++;
            if (noise) begin
                start = 1'b1;
                x     = N'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_latency", 32'(done), 32'(1));
        chk("busy_in_done", 32'(busy), 32'(0));
        chk("busy_cycles", 32'(busy_n), 32'(N));
        clear_acc = clr;
        @(posedge clk); #1;
        clear_acc = 1'b0;
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    task automatic pulse_clear();
        clear_acc = 1'b1;
        @(posedge clk); #1;
        clear_acc = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; clear_acc = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_outputs", 32'({busy, done, count, match, acc, acc_sat}), 32'(0));

        // Basic word, then all-zero and all-one words
        run_word(16'hAA55, 1'b0, 1'b0);
        run_word(16'h0000, 1'b0, 1'b0);
        run_word(16'hFFFF, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;

        // start pulsed during SHIFT must be ignored
        run_word(16'h0F0F, 1'b0, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Back-to-back: three words with start held high
        b2b   = 1'b1;
        start = 1'b1;
        x     = 16'h0001;
        for (int i = 0; i < 3; i++) q.push_back(mk_exp(16'h0001));
        @(posedge clk);
        repeat (2 * (N + 1)) @(posedge clk);
        #1 start = 1'b0;
        repeat (N + 2) @(posedge clk); #1;
        b2b = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Saturation, then clear in the DONE cycle
        pulse_clear();
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) run_word(16'hFFFF, 1'b0, 1'b0);
        run_word(16'hFFFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset mid-SHIFT discards the word in flight
        start = 1'b1;
        x     = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'({busy, done, count, match, acc, acc_sat}), 32'(0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (N + 3) @(posedge clk); #1;
        chk("no_done_after_reset", 32'(done), 32'(0));
        run_word(16'h00FF, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;

        chk("scoreboard_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
